// File: rtl/bcd_pkg.sv
// Shared BCD types, constants and helpers.
// Used by the digit slice and the packed-BCD adder top.
package bcd_pkg;

  typedef logic [3:0] bcd_digit_t;

  localparam int unsigned BCD_MAX_DIGIT  = 9;
  localparam int unsigned BCD_CORRECTION = 6;

  function automatic logic bcd_digit_valid(
    input bcd_digit_t d
  );
    return ({28'd0, d} <= BCD_MAX_DIGIT);
  endfunction

endpackage

// File: rtl/bcd_digit_add.sv
// One combinational BCD digit slice with decimal carry.
// Optional invalid-digit flag: BCD_ADDER_INVALID_CHECK_EN.
import bcd_pkg::*;

module bcd_digit_add (
  input  bcd_digit_t a_d,
  input  bcd_digit_t b_d,
  input  logic       c_in,
  output bcd_digit_t s_d,
  output logic       c_out
`ifdef BCD_ADDER_INVALID_CHECK_EN
  ,
  output logic       bad
`endif
);

  logic [4:0] t;
  logic [4:0] tc;

  // Binary digit sum, corrected by six when it leaves 0..9
  always_comb begin
    t     = {1'b0, a_d} + {1'b0, b_d} + {4'd0, c_in};
    tc    = t + 5'(BCD_CORRECTION);
    c_out = (t > 5'(BCD_MAX_DIGIT));
    s_d   = c_out ? tc[3:0] : t[3:0];
  end

`ifdef BCD_ADDER_INVALID_CHECK_EN
  // Flag a digit outside the decimal range on either operand
  always_comb begin
    bad = !bcd_digit_valid(a_d) || !bcd_digit_valid(b_d);
  end
`endif

endmodule

// File: rtl/bcd_adder_2digit.sv
// Registered packed-BCD adder, one-cycle latency.
// Optional invalid-digit flag: BCD_ADDER_INVALID_CHECK_EN.
import bcd_pkg::*;

module bcd_adder_2digit #(
  parameter int NUM_DIGITS = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  input  logic [4*NUM_DIGITS-1:0] a,
  input  logic [4*NUM_DIGITS-1:0] b,
  input  logic                    cin,
  output logic [4*NUM_DIGITS-1:0] sum,
  output logic                    cout,
  output logic                    out_valid,
  output logic                    err
);

  logic [NUM_DIGITS:0]     c;
  logic [4*NUM_DIGITS-1:0] s;

  assign c[0] = cin;

`ifdef BCD_ADDER_INVALID_CHECK_EN
  logic [NUM_DIGITS-1:0] bad;
`endif

  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_dig
    bcd_digit_add u_dig (
      .a_d   (a[4*i +: 4]),
      .b_d   (b[4*i +: 4]),
      .c_in  (c[i]),
      .s_d   (s[4*i +: 4]),
      .c_out (c[i+1])
`ifdef BCD_ADDER_INVALID_CHECK_EN
      ,
      .bad   (bad[i])
`endif
    );
  end

  // Capture result on accepted operands, hold otherwise
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum       <= '0;
      cout      <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        sum  <= s;
        cout <= c[NUM_DIGITS];
      end
    end
  end

`ifdef BCD_ADDER_INVALID_CHECK_EN
  // Register invalid-digit flag alongside the sum
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err <= 1'b0;
    end else if (in_valid) begin
      err <= |bad;
    end
  end
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_bcd_adder_2digit.sv
// Directed table-driven bench for bcd_adder_2digit.
// Expects err only when BCD_ADDER_INVALID_CHECK_EN is defined.
module tb_bcd_adder_2digit;

`ifdef BCD_ADDER_INVALID_CHECK_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic [7:0] a;
  logic [7:0] b;
  logic       cin;
  logic [7:0] sum;
  logic       cout;
  logic       out_valid;
  logic       err;

  int checks;
  int errors;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] s;
    logic       co;
    logic       bad;
  } vec_t;

  vec_t vt[11];

  bcd_adder_2digit #(.NUM_DIGITS(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sum       (sum),
    .cout      (cout),
    .out_valid (out_valid),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(
    input string       name,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h",
               name, act, exp);
    end
  endtask

  task automatic chk_out(
    input string      name,
    input logic [7:0] es,
    input logic       ec,
    input logic       ev,
    input logic       ee
  );
    chk({name, ".sum"}, 32'(sum), 32'(es));
    chk({name, ".cout"}, 32'(cout), 32'(ec));
    chk({name, ".ov"}, 32'(out_valid), 32'(ev));
    chk({name, ".err"}, 32'(err), 32'(ee));
  endtask

  task automatic drive(
    input logic       v,
    input logic [7:0] ia,
    input logic [7:0] ib,
    input logic       ic
  );
    @(negedge clk);
    in_valid = v;
    a        = ia;
    b        = ib;
    cin      = ic;
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    vt[0]  = '{8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 1'b0};
    vt[1]  = '{8'h09, 8'h09, 1'b1, 8'h19, 1'b0, 1'b0};
    vt[2]  = '{8'h10, 8'h01, 1'b0, 8'h11, 1'b0, 1'b0};
    vt[3]  = '{8'h41, 8'h11, 1'b0, 8'h52, 1'b0, 1'b0};
    vt[4]  = '{8'h99, 8'h99, 1'b1, 8'h99, 1'b1, 1'b0};
    vt[5]  = '{8'h50, 8'h50, 1'b0, 8'h00, 1'b1, 1'b0};
    vt[6]  = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0};
    vt[7]  = '{8'h45, 8'h54, 1'b1, 8'h00, 1'b1, 1'b0};
    vt[8]  = '{8'h19, 8'h01, 1'b0, 8'h20, 1'b0, 1'b0};
    vt[9]  = '{8'h0A, 8'h01, 1'b0, 8'h11, 1'b0, 1'b1};
    vt[10] = '{8'h99, 8'h0F, 1'b0, 8'h0E, 1'b1, 1'b1};

    rst_n    = 1'b0;
    in_valid = 1'b1;
    a        = 8'($urandom);
    b        = 8'($urandom);
    cin      = 1'b1;
    #1;
    chk_out("rst_async", 8'h00, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      a   = 8'($urandom);
      b   = 8'($urandom);
      cin = 1'($urandom);
    end
    @(posedge clk);
    #1;
    chk_out("rst_hold", 8'h00, 1'b0, 1'b0, 1'b0);

    @(negedge clk);
    rst_n    = 1'b1;
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 8'h77, 8'h22, 1'b1);
      chk_out("idle", 8'h00, 1'b0, 1'b0, 1'b0);
    end

    for (int i = 0; i < 11; i++) begin
      drive(1'b1, vt[i].a, vt[i].b, vt[i].cin);
      chk_out($sformatf("vec%0d", i), vt[i].s,
              vt[i].co, 1'b1, ERR_EN & vt[i].bad);
      drive(1'b0, 8'h33, 8'h33, 1'b0);
      chk_out($sformatf("vec%0d_hold", i), vt[i].s,
              vt[i].co, 1'b0, ERR_EN & vt[i].bad);
    end

    drive(1'b1, 8'h12, 8'h34, 1'b0);
    chk_out("b2b0", 8'h46, 1'b0, 1'b1, 1'b0);
    drive(1'b1, 8'h58, 8'h47, 1'b1);
    chk_out("b2b1", 8'h06, 1'b1, 1'b1, 1'b0);
    drive(1'b1, 8'h0B, 8'h00, 1'b0);
    chk_out("b2b2", 8'h11, 1'b0, 1'b1, ERR_EN);
    drive(1'b0, 8'h99, 8'h99, 1'b1);
    chk_out("drop", 8'h11, 1'b0, 1'b0, ERR_EN);
    drive(1'b0, 8'h01, 8'h02, 1'b0);
    chk_out("drop2", 8'h11, 1'b0, 1'b0, ERR_EN);

    drive(1'b1, 8'h37, 8'h25, 1'b0);
    chk_out("pre_rst", 8'h62, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    in_valid = 1'b1;
    a        = 8'h99;
    b        = 8'h99;
    cin      = 1'b1;
    rst_n    = 1'b0;
    #1;
    chk_out("rst_mid", 8'h00, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    chk_out("rst_edge", 8'h00, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n    = 1'b1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    chk_out("rst_after", 8'h00, 1'b0, 1'b0, 1'b0);

    drive(1'b1, 8'h88, 8'h11, 1'b1);
    chk_out("post_rst", 8'h00, 1'b1, 1'b1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bcd_adder_2digit.md
Name: bcd_adder_2digit

Overview:
- Registered packed-BCD adder; adds two NUM_DIGITS-digit BCD operands plus a carry-in and produces a BCD sum and decimal carry-out.
- Default is 2 digits (8-bit operands, range 00-99).
- Arithmetic datapath leaf used wherever decimal counters or displays need BCD addition.
- One-cycle registered latency with a simple valid strobe.

Parameters:
- NUM_DIGITS, 2, number of BCD digits per operand. Operand width is 4*NUM_DIGITS. Legal range 1..8.

Ports:
- clk  input  1  single clock; all state updates on rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operands and cin are sampled on a rising edge while high
- a  input  4*NUM_DIGITS  operand A, packed BCD, digit 0 in bits [3:0]
- b  input  4*NUM_DIGITS  operand B, packed BCD
- cin  input  1  decimal carry-in to digit 0
- sum  output  4*NUM_DIGITS  registered packed-BCD sum
- cout  output  1  registered decimal carry-out of the most significant digit
- out_valid  output  1  high for exactly one cycle when sum/cout hold a new result
- err  output  1  registered invalid-digit flag (see Optional Feature)

Behaviour:
- Reset (rst_n low, asynchronous):
  - sum=0, cout=0, out_valid=0, err=0 immediately.
  - Reset asserted mid-operation discards any sampled operands; no result is produced for them.
- Per-digit rule, rippled from digit 0 upward with c0=cin:
  - t = a_i + b_i + c_i, computed 5 bits wide.
  - If t > 9: s_i = (t + 6)[3:0] and c_{i+1} = 1.
  - Otherwise: s_i = t[3:0] and c_{i+1} = 0.
- cout = c_NUM_DIGITS. The maximum legal result is 99+99+1 = 199, giving sum=99 and cout=1.
- The ripple is purely combinational; there are no internal pipeline stages.
- Latency: operands sampled at edge N while in_valid=1 appear on sum/cout with out_valid=1 after edge N.
- in_valid low at an edge: out_valid=0 after that edge; sum, cout and err hold their previous values.
- Back-to-back in_valid: one result per cycle, full throughput, no backpressure.
- Wrap-around: a carry out of the top digit goes only to cout; sum is the result modulo 10^NUM_DIGITS.
- Non-BCD input digits (>9) are not rejected. The same rule is applied to the 5-bit t, so the output is deterministic but not a meaningful decimal value.

Optional Feature:
- Macro: BCD_ADDER_INVALID_CHECK_EN.
- Defined:
  - err is registered together with sum on every accepted operation.
  - err=1 if any digit of a or b is greater than 9; otherwise err=0.
  - sum and cout are still computed by the normal rule.
  - err resets to 0 and holds when in_valid is low.
- Not defined:
  - err is tied to 0.
  - No digit-compare logic is synthesized.

Decomposition:
- Package bcd_pkg:
  - typedef bcd_digit_t (logic [3:0])
  - constants BCD_MAX_DIGIT=9 and BCD_CORRECTION=6
  - a function bcd_digit_valid() returning whether a digit is 9 or less
- Sub-module bcd_digit_add, one combinational digit slice:
  - inputs a_d, b_d, c_in
  - outputs s_d, c_out, bad (digit invalid)
  - Instantiated NUM_DIGITS times in a generate loop.
- The top-level holds the carry chain and the output registers.

Test Plan:
- Reset: hold rst_n=0 with random inputs -> sum=00, cout=0, out_valid=0, err=0. Release and idle -> outputs stay 0.
- Basic and per-digit carry:
  - a=01, b=01, cin=0 -> sum=02, cout=0, out_valid one cycle later.
  - a=09, b=09, cin=1 -> sum=19, cout=0.
- Cross-digit operands:
  - a=10, b=01, cin=0 -> sum=11, cout=0.
  - a=41, b=11, cin=0 -> sum=52, cout=0.
- Maximum and wrap:
  - a=99, b=99, cin=1 -> sum=99, cout=1.
  - a=50, b=50, cin=0 -> sum=00, cout=1.
- Handshake:
  - Back-to-back in_valid for 3 cycles -> 3 consecutive out_valid pulses with matching results.
  - Drop in_valid -> out_valid=0, sum holds.
  - Assert rst_n low in the same cycle as in_valid -> no out_valid, outputs 0.
- Invalid digit: a=0A, b=01, cin=0 -> with BCD_ADDER_INVALID_CHECK_EN, err=1; without it, err=0. In both builds sum=11, cout=0.
